pipelined_adder: RTL

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 14 +
 rtl/add_slice.sv | 16 +
 rtl/pipelined_adder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared width limits and slice sizing for pipelined_adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    localparam int ADDER_MIN_WIDTH = 4;
    localparam int ADDER_MAX_WIDTH = 64;

    // Bits handled per pipeline stage; callers keep width divisible by stages.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// One SLICE-bit ripple add with carry in/out; purely combinational.
// Latency: 0 cycles.
// Backpressure: none; the enclosing stage register decides when to capture.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c_in};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-registered pipelined adder, STAGES slices; ovf output under PIPELINED_ADDER_OVF_EN.
// Latency: STAGES cycles from acceptance to out_valid.
// Backpressure: whole pipe advances when out_ready | ~out_valid, otherwise holds; in_ready mirrors that.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    logic advance;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Stage k owns finished sum bits [0 +: (k+1)*SLICE] and the operand bits not yet added.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = (k + 1) * SLICE;
        localparam int RW = WIDTH - SW;

        logic             vld_q, vld_d;
        logic             cy_q, cy_d;
        logic [SW-1:0]    sum_q, sum_d;
        logic             prev_vld;
        logic             cin;
        logic             cout;
        logic [SLICE-1:0] op_a, op_b, slice_sum;
        logic [SW-1:0]    sum_in;

        if (k == 0) begin : g_src
            assign prev_vld = in_valid;
            assign op_a     = a[SLICE-1:0];
            assign op_b     = b[SLICE-1:0];
            assign cin      = c_in;
            assign sum_in   = slice_sum;
        end else begin : g_src
            assign prev_vld = g_stage[k-1].vld_q;
            assign op_a     = g_stage[k-1].g_rem.ra_q[SLICE-1:0];
            assign op_b     = g_stage[k-1].g_rem.rb_q[SLICE-1:0];
            assign cin      = g_stage[k-1].cy_q;
            assign sum_in   = {slice_sum, g_stage[k-1].sum_q};
        end

        add_slice #(.SLICE(SLICE)) u_slice (
            .a     (op_a),
            .b     (op_b),
            .c_in  (cin),
            .sum   (slice_sum),
            .c_out (cout)
        );

        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            sum_d = sum_q;
            if (advance) begin
                vld_d = prev_vld;
                cy_d  = cout;
                sum_d = sum_in;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
            end
        end

        if (RW > 0) begin : g_rem
            logic [RW-1:0] ra_q, ra_d, rb_q, rb_d;
            logic [RW-1:0] ra_in, rb_in;

            if (k == 0) begin : g_first
                assign ra_in = a[WIDTH-1:SLICE];
                assign rb_in = b[WIDTH-1:SLICE];
            end else begin : g_next
                assign ra_in = g_stage[k-1].g_rem.ra_q[RW+SLICE-1:SLICE];
                assign rb_in = g_stage[k-1].g_rem.rb_q[RW+SLICE-1:SLICE];
            end

            always_comb begin
                ra_d = ra_q;
                rb_d = rb_q;
                if (advance) begin
                    ra_d = ra_in;
                    rb_d = rb_in;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign c_out     = g_stage[STAGES-1].cy_q;

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic top_a_msb, top_b_msb, top_s_msb;

    // Sign bits are taken where the top slice is added, so ovf lands with sum.
    assign top_a_msb = g_stage[STAGES-1].op_a[SLICE-1];
    assign top_b_msb = g_stage[STAGES-1].op_b[SLICE-1];
    assign top_s_msb = g_stage[STAGES-1].slice_sum[SLICE-1];

    always_comb begin
        ovf_d = ovf_q;
        if (advance) begin
            ovf_d = (top_a_msb == top_b_msb) & (top_s_msb != top_a_msb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
